axi4_lite_sram: RTL and testbench

- AXI4-Lite responder (slave) backed by an internal word-addressed SRAM array.
- Serves as the memory/peripheral endpoint on the far side of the core's AXI4-Lite initiator, replacing DPI memory in standalone simulation.
- Read and write channels run independently.
- Each channel has a programmable fixed response latency to exercise initiator stall handling.

---
 rtl/axi4_lite_sram_if.sv | 39 +++
 rtl/axi4_lite_sram.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi4_lite_sram.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_sram_if.sv
// AXI4-Lite bus bundle between an initiator and the SRAM responder.
interface axi4_lite_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int RESP_WIDTH = 2
);
  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_WIDTH-1:0] ar_bits_addr;
  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_bits_data;
  logic [RESP_WIDTH-1:0] r_bits_resp;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_WIDTH-1:0] aw_bits_addr;
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_bits_data;
  logic [MASK_WIDTH-1:0] w_bits_strb;
  logic                  b_valid;
  logic                  b_ready;
  logic [RESP_WIDTH-1:0] b_bits_resp;

  modport master (
    output ar_valid, ar_bits_addr, r_ready,
    output aw_valid, aw_bits_addr, w_valid, w_bits_data, w_bits_strb, b_ready,
    input  ar_ready, r_valid, r_bits_data, r_bits_resp,
    input  aw_ready, w_ready, b_valid, b_bits_resp
  );

  modport slave (
    input  ar_valid, ar_bits_addr, r_ready,
    input  aw_valid, aw_bits_addr, w_valid, w_bits_data, w_bits_strb, b_ready,
    output ar_ready, r_valid, r_bits_data, r_bits_resp,
    output aw_ready, w_ready, b_valid, b_bits_resp
  );
endinterface

// File: rtl/axi4_lite_sram.sv
// AXI4-Lite responder over a word-addressed SRAM with independent read/write
// channels, each with a fixed programmable response latency.
module axi4_lite_sram #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MASK_WIDTH = 4,
  parameter int                    RESP_WIDTH = 2,
  parameter int                    DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    RD_DELAY   = 2,
  parameter int                    WR_DELAY   = 1
) (
  input  logic                   iClock,
  input  logic                   iReset,
  axi4_lite_sram_if.slave        pAXI4
);
  localparam int                    IDXW   = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN   = ADDR_WIDTH'(DEPTH * 4);
  localparam logic [3:0]            RD_CNT = 4'(RD_DELAY);
  localparam logic [3:0]            WR_CNT = 4'(WR_DELAY);
  localparam logic [RESP_WIDTH-1:0] OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] DECERR = '1;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  r_state_e              r_state_q, r_state_d;
  logic [3:0]            rcnt_q, rcnt_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0] rresp_q, rresp_d;

  w_state_e              w_state_q, w_state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [RESP_WIDTH-1:0] bresp_q, bresp_d;

  logic                  ar_hs, aw_hs, w_hs;
  logic                  r_sample, w_commit, w_we;
  logic [ADDR_WIDTH-1:0] r_addr, r_off, w_addr, w_off;
  logic [DATA_WIDTH-1:0] w_data;
  logic [MASK_WIDTH-1:0] w_strb;
  logic [IDXW-1:0]       r_idx, w_idx;
  logic                  r_ok, w_ok;

  assign ar_hs = pAXI4.ar_valid & arready_q;
  assign aw_hs = pAXI4.aw_valid & awready_q;
  assign w_hs  = pAXI4.w_valid  & wready_q;

  // Offsets wrap modulo 2^ADDR_WIDTH, so addresses below BASE_ADDR land far out of range.
  assign r_off = r_addr - BASE_ADDR;
  assign r_ok  = r_off < SPAN;
  assign r_idx = r_off[IDXW+1:2];
  assign w_off = w_addr - BASE_ADDR;
  assign w_ok  = w_off < SPAN;
  assign w_idx = w_off[IDXW+1:2];

  always_comb begin
    r_state_d = r_state_q;
    rcnt_d    = rcnt_q;
    araddr_d  = araddr_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_sample  = 1'b0;
    r_addr    = araddr_q;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          araddr_d  = pAXI4.ar_bits_addr;
          arready_d = 1'b0;
          rcnt_d    = RD_CNT;
          if (RD_DELAY == 0) begin
            r_state_d = R_RESP;
            r_sample  = 1'b1;
            r_addr    = pAXI4.ar_bits_addr;
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (rcnt_q == 4'd0) begin
          r_state_d = R_RESP;
          r_sample  = 1'b1;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (pAXI4.r_ready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Sampling here sees the array before any commit on the same edge.
    if (r_sample) begin
      rvalid_d = 1'b1;
      rresp_d  = r_ok ? OKAY : DECERR;
      rdata_d  = r_ok ? mem_q[r_idx] : '0;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    wcnt_d    = wcnt_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    w_commit  = 1'b0;
    w_addr    = awaddr_q;
    w_data    = wdata_q;
    w_strb    = wstrb_q;
    unique case (w_state_q)
      W_IDLE: begin
        aw_got_d = aw_got_q | aw_hs;
        w_got_d  = w_got_q | w_hs;
        if (aw_hs) awaddr_d = pAXI4.aw_bits_addr;
        if (w_hs) begin
          wdata_d = pAXI4.w_bits_data;
          wstrb_d = pAXI4.w_bits_strb;
        end
        awready_d = ~aw_got_d;
        wready_d  = ~w_got_d;
        if (aw_got_d && w_got_d) begin
          wcnt_d = WR_CNT;
          if (WR_DELAY == 0) begin
            w_state_d = W_RESP;
            w_commit  = 1'b1;
            w_addr    = awaddr_d;
            w_data    = wdata_d;
            w_strb    = wstrb_d;
          end else begin
            w_state_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (wcnt_q == 4'd0) begin
          w_state_d = W_RESP;
          w_commit  = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      W_RESP: begin
        if (pAXI4.b_ready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (w_commit) begin
      bvalid_d = 1'b1;
      bresp_d  = w_ok ? OKAY : DECERR;
    end
  end

  assign w_we = w_commit & w_ok;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state_q <= R_IDLE;
      rcnt_q    <= '0;
      araddr_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      w_state_q <= W_IDLE;
      wcnt_q    <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      rcnt_q    <= rcnt_d;
      araddr_q  <= araddr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      wcnt_q    <= wcnt_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Array is deliberately left unreset; a reset before commit simply never writes.
  always_ff @(posedge iClock) begin
    if (w_we) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (w_strb[b]) mem_q[w_idx][b*8 +: 8] <= w_data[b*8 +: 8];
      end
    end
  end

  assign pAXI4.ar_ready    = arready_q;
  assign pAXI4.r_valid     = rvalid_q;
  assign pAXI4.r_bits_data = rdata_q;
  assign pAXI4.r_bits_resp = rresp_q;
  assign pAXI4.aw_ready    = awready_q;
  assign pAXI4.w_ready     = wready_q;
  assign pAXI4.b_valid     = bvalid_q;
  assign pAXI4.b_bits_resp = bresp_q;
endmodule

// File: tb/tb_axi4_lite_sram.sv
// Directed bench for axi4_lite_sram: timing, strobes, decode, back-pressure, reset abort.
module tb_axi4_lite_sram;
  logic iClock = 1'b0;
  logic iReset;
  int   nvec = 0;
  int   nerr = 0;

  axi4_lite_sram_if bus ();

  axi4_lite_sram dut (
    .iClock (iClock),
    .iReset (iReset),
    .pAXI4  (bus)
  );

  always #5 iClock = ~iClock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] rs);
    int n;
    rs = 'x;
    n = 0;
    while (!(bus.aw_ready === 1'b1 && bus.w_ready === 1'b1) && n < 20) begin tick(); n++; end
    if (n == 20) return;
    bus.aw_valid = 1'b1; bus.aw_bits_addr = a;
    bus.w_valid = 1'b1; bus.w_bits_data = d; bus.w_bits_strb = s;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    n = 0;
    while (bus.b_valid !== 1'b1 && n < 20) begin tick(); n++; end
    if (n == 20) return;
    rs = bus.b_bits_resp;
    bus.b_ready = 1'b1; tick(); bus.b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] rs);
    int n;
    d = 'x; rs = 'x;
    n = 0;
    while (bus.ar_ready !== 1'b1 && n < 20) begin tick(); n++; end
    if (n == 20) return;
    bus.ar_valid = 1'b1; bus.ar_bits_addr = a;
    tick();
    bus.ar_valid = 1'b0;
    n = 0;
    while (bus.r_valid !== 1'b1 && n < 20) begin tick(); n++; end
    if (n == 20) return;
    d = bus.r_bits_data; rs = bus.r_bits_resp;
    bus.r_ready = 1'b1; tick(); bus.r_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    iReset = 1'b0;
    #2 iReset = 1'b1;
    #1;
    outs = {bus.ar_ready, bus.r_valid, bus.aw_ready, bus.w_ready, bus.b_valid,
            bus.r_bits_resp, bus.b_bits_resp, 5'(bus.r_bits_data != 0)};
    nvec++; if (outs !== 14'd0) begin nerr++; $display("FAIL reset_outs: got %h want %h", outs, 14'd0); end
    nvec++; if (bus.r_bits_data !== 32'd0) begin nerr++; $display("FAIL reset_rdata: got %h want %h", bus.r_bits_data, 32'd0); end
    tick(); tick();
    nvec++; if (bus.ar_ready !== 1'b0) begin nerr++; $display("FAIL reset_hold_arready: got %b want 0", bus.ar_ready); end
    iReset = 1'b0;
    tick();
    nvec++; if (bus.ar_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_arready: got %b want 1", bus.ar_ready); end
    nvec++; if ({bus.aw_ready, bus.w_ready} !== 2'b11) begin nerr++; $display("FAIL post_reset_awwready: got %b want 11", {bus.aw_ready, bus.w_ready}); end
  endtask

  task automatic test_write_read();
    bus.aw_valid = 1'b1; bus.aw_bits_addr = 32'h8000_0010;
    bus.w_valid = 1'b1; bus.w_bits_data = 32'hDEAD_BEEF; bus.w_bits_strb = 4'hF;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    nvec++; if ({bus.aw_ready, bus.w_ready, bus.b_valid} !== 3'b000) begin nerr++; $display("FAIL wr_capture: got %b want 000", {bus.aw_ready, bus.w_ready, bus.b_valid}); end
    tick();
    nvec++; if (bus.b_valid !== 1'b0) begin nerr++; $display("FAIL wr_bvalid_early: got %b want 0", bus.b_valid); end
    tick();
    nvec++; if (bus.b_valid !== 1'b1) begin nerr++; $display("FAIL wr_bvalid_at2: got %b want 1", bus.b_valid); end
    nvec++; if (bus.b_bits_resp !== 2'b00) begin nerr++; $display("FAIL wr_bresp: got %b want 00", bus.b_bits_resp); end
    bus.b_ready = 1'b1; tick(); bus.b_ready = 1'b0;
    nvec++; if ({bus.b_valid, bus.aw_ready, bus.w_ready} !== 3'b011) begin nerr++; $display("FAIL wr_done: got %b want 011", {bus.b_valid, bus.aw_ready, bus.w_ready}); end

    bus.ar_valid = 1'b1; bus.ar_bits_addr = 32'h8000_0010;
    tick();
    bus.ar_valid = 1'b0;
    nvec++; if ({bus.ar_ready, bus.r_valid} !== 2'b00) begin nerr++; $display("FAIL rd_accept: got %b want 00", {bus.ar_ready, bus.r_valid}); end
    tick();
    nvec++; if (bus.r_valid !== 1'b0) begin nerr++; $display("FAIL rd_valid_c1: got %b want 0", bus.r_valid); end
    tick();
    nvec++; if (bus.r_valid !== 1'b0) begin nerr++; $display("FAIL rd_valid_c2: got %b want 0", bus.r_valid); end
    tick();
    nvec++; if (bus.r_valid !== 1'b1) begin nerr++; $display("FAIL rd_valid_c3: got %b want 1", bus.r_valid); end
    nvec++; if (bus.r_bits_data !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL rd_data: got %h want %h", bus.r_bits_data, 32'hDEAD_BEEF); end
    nvec++; if (bus.r_bits_resp !== 2'b00) begin nerr++; $display("FAIL rd_resp: got %b want 00", bus.r_bits_resp); end
    bus.r_ready = 1'b1; tick(); bus.r_ready = 1'b0;
    nvec++; if ({bus.r_valid, bus.ar_ready} !== 2'b01) begin nerr++; $display("FAIL rd_done: got %b want 01", {bus.r_valid, bus.ar_ready}); end
  endtask

  task automatic test_strobe();
    logic [1:0] rs; logic [31:0] d;
    do_write(32'h8000_0010, 32'h1122_3344, 4'b0101, rs);
    nvec++; if (rs !== 2'b00) begin nerr++; $display("FAIL strb_bresp: got %b want 00", rs); end
    do_read(32'h8000_0010, d, rs);
    nvec++; if (d !== 32'hDE22_BE44) begin nerr++; $display("FAIL strb_data: got %h want %h", d, 32'hDE22_BE44); end
    do_write(32'h8000_0012, 32'hFFFF_FFFF, 4'b0000, rs);
    nvec++; if (rs !== 2'b00) begin nerr++; $display("FAIL strb0_bresp: got %b want 00", rs); end
    do_read(32'h8000_0013, d, rs);
    nvec++; if (d !== 32'hDE22_BE44) begin nerr++; $display("FAIL strb0_data: got %h want %h", d, 32'hDE22_BE44); end
  endtask

  task automatic test_w_first();
    logic [1:0] rs; logic [31:0] d;
    do_write(32'h8000_0020, 32'h0101_0101, 4'hF, rs);
    bus.w_valid = 1'b1; bus.w_bits_data = 32'hCAFE_F00D; bus.w_bits_strb = 4'hF;
    tick();
    bus.w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nvec++; if ({bus.w_ready, bus.aw_ready, bus.b_valid} !== 3'b010) begin nerr++; $display("FAIL wfirst_wait%0d: got %b want 010", i, {bus.w_ready, bus.aw_ready, bus.b_valid}); end
      tick();
    end
    bus.aw_valid = 1'b1; bus.aw_bits_addr = 32'h8000_0020;
    tick();
    bus.aw_valid = 1'b0;
    nvec++; if (bus.aw_ready !== 1'b0) begin nerr++; $display("FAIL wfirst_awready: got %b want 0", bus.aw_ready); end
    tick();
    nvec++; if (bus.b_valid !== 1'b0) begin nerr++; $display("FAIL wfirst_bvalid_c1: got %b want 0", bus.b_valid); end
    tick();
    for (int i = 0; i < 3; i++) begin
      nvec++; if (bus.b_valid !== 1'b1) begin nerr++; $display("FAIL wfirst_bhold%0d: got %b want 1", i, bus.b_valid); end
      if (i < 2) tick();
    end
    bus.b_ready = 1'b1; tick(); bus.b_ready = 1'b0;
    nvec++; if (bus.b_valid !== 1'b0) begin nerr++; $display("FAIL wfirst_bdrop: got %b want 0", bus.b_valid); end
    tick();
    nvec++; if (bus.b_valid !== 1'b0) begin nerr++; $display("FAIL wfirst_bpulse: got %b want 0", bus.b_valid); end
    do_read(32'h8000_0020, d, rs);
    nvec++; if (d !== 32'hCAFE_F00D) begin nerr++; $display("FAIL wfirst_data: got %h want %h", d, 32'hCAFE_F00D); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] rs; logic [31:0] d;
    do_write(32'h8000_0000, 32'h5A5A_5A5A, 4'hF, rs);
    do_write(32'h8000_03FC, 32'h1234_5678, 4'hF, rs);
    nvec++; if (rs !== 2'b00) begin nerr++; $display("FAIL oor_top_bresp: got %b want 00", rs); end
    do_read(32'h8000_0400, d, rs);
    nvec++; if (rs !== 2'b11) begin nerr++; $display("FAIL oor_rresp: got %b want 11", rs); end
    nvec++; if (d !== 32'd0) begin nerr++; $display("FAIL oor_rdata: got %h want 0", d); end
    do_write(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, rs);
    nvec++; if (rs !== 2'b11) begin nerr++; $display("FAIL oor_bresp: got %b want 11", rs); end
    do_read(32'h8000_0000, d, rs);
    nvec++; if (d !== 32'h5A5A_5A5A) begin nerr++; $display("FAIL oor_word0: got %h want %h", d, 32'h5A5A_5A5A); end
    do_read(32'h8000_03FC, d, rs);
    nvec++; if (d !== 32'h1234_5678 || rs !== 2'b00) begin nerr++; $display("FAIL oor_word255: got %h/%b want %h/00", d, rs, 32'h1234_5678); end
  endtask

  task automatic test_backpressure();
    logic [1:0] rs; logic [31:0] d; logic [1:0] bresp; int bseen; int n;
    bseen = 0; bresp = 'x;
    bus.ar_valid = 1'b1; bus.ar_bits_addr = 32'h8000_0010;
    bus.aw_valid = 1'b1; bus.aw_bits_addr = 32'h8000_0030;
    bus.w_valid = 1'b1; bus.w_bits_data = 32'h0BAD_C0DE; bus.w_bits_strb = 4'hF;
    bus.b_ready = 1'b1;
    tick();
    bus.ar_valid = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    n = 0;
    while (bus.r_valid !== 1'b1 && n < 20) begin
      tick(); n++;
      if (bus.b_valid === 1'b1) begin bseen++; bresp = bus.b_bits_resp; end
    end
    for (int i = 0; i < 5; i++) begin
      nvec++; if ({bus.r_valid, bus.ar_ready} !== 2'b10 || bus.r_bits_data !== 32'hDE22_BE44)
        begin nerr++; $display("FAIL bp_stall%0d: got %b/%h want 10/%h", i, {bus.r_valid, bus.ar_ready}, bus.r_bits_data, 32'hDE22_BE44); end
      tick();
      if (bus.b_valid === 1'b1) begin bseen++; bresp = bus.b_bits_resp; end
    end
    bus.b_ready = 1'b0;
    nvec++; if (bseen !== 1 || bresp !== 2'b00) begin nerr++; $display("FAIL bp_write: got %0d/%b want 1/00", bseen, bresp); end
    bus.r_ready = 1'b1; tick(); bus.r_ready = 1'b0;
    nvec++; if (bus.r_valid !== 1'b0) begin nerr++; $display("FAIL bp_rdrop: got %b want 0", bus.r_valid); end
    do_read(32'h8000_0030, d, rs);
    nvec++; if (d !== 32'h0BAD_C0DE) begin nerr++; $display("FAIL bp_wdata: got %h want %h", d, 32'h0BAD_C0DE); end
  endtask

  task automatic test_reset_abort();
    logic [1:0] rs; logic [31:0] d; int seen;
    do_write(32'h8000_0040, 32'h1111_1111, 4'hF, rs);
    bus.ar_valid = 1'b1; bus.ar_bits_addr = 32'h8000_0040;
    bus.aw_valid = 1'b1; bus.aw_bits_addr = 32'h8000_0040;
    bus.w_valid = 1'b1; bus.w_bits_data = 32'h2222_2222; bus.w_bits_strb = 4'hF;
    tick();
    bus.ar_valid = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    iReset = 1'b1;
    #1;
    nvec++; if ({bus.ar_ready, bus.r_valid, bus.aw_ready, bus.w_ready, bus.b_valid} !== 5'd0)
      begin nerr++; $display("FAIL abort_outs: got %b want 00000", {bus.ar_ready, bus.r_valid, bus.aw_ready, bus.w_ready, bus.b_valid}); end
    tick();
    iReset = 1'b0;
    bus.r_ready = 1'b1; bus.b_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.r_valid === 1'b1 || bus.b_valid === 1'b1) seen++;
    end
    bus.r_ready = 1'b0; bus.b_ready = 1'b0;
    nvec++; if (seen !== 0) begin nerr++; $display("FAIL abort_noresp: got %0d want 0", seen); end
    nvec++; if ({bus.ar_ready, bus.aw_ready, bus.w_ready} !== 3'b111) begin nerr++; $display("FAIL abort_ready: got %b want 111", {bus.ar_ready, bus.aw_ready, bus.w_ready}); end
    do_read(32'h8000_0040, d, rs);
    nvec++; if (d !== 32'h1111_1111) begin nerr++; $display("FAIL abort_data: got %h want %h", d, 32'h1111_1111); end
  endtask

  initial begin
    bus.ar_valid = 1'b0; bus.ar_bits_addr = '0; bus.r_ready = 1'b0;
    bus.aw_valid = 1'b0; bus.aw_bits_addr = '0;
    bus.w_valid = 1'b0; bus.w_bits_data = '0; bus.w_bits_strb = '0; bus.b_ready = 1'b0;
    test_reset();
    test_write_read();
    test_strobe();
    test_w_first();
    test_out_of_range();
    test_backpressure();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
